// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the TX scheduler, the FWFT async FIFO read port and the UART TX.
// The master modport is the scheduler side; the slave modport is the FIFO/UART environment.
interface uart_tx_sched_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  Sched_EN;
  logic                  FIFO_EMPTY;
  logic [DATA_WIDTH-1:0] FIFO_RdData;
  logic                  TX_Busy;
  logic                  FIFO_RdInc;
  logic [DATA_WIDTH-1:0] TX_P_Data;
  logic                  TX_D_VLD;
  logic [7:0]            Frame_Count;
  logic                  Retry_Err;

  modport master (
    input  Sched_EN,
    input  FIFO_EMPTY,
    input  FIFO_RdData,
    input  TX_Busy,
    output FIFO_RdInc,
    output TX_P_Data,
    output TX_D_VLD,
    output Frame_Count,
    output Retry_Err
  );

  modport slave (
    output Sched_EN,
    output FIFO_EMPTY,
    output FIFO_RdData,
    output TX_Busy,
    input  FIFO_RdInc,
    input  TX_P_Data,
    input  TX_D_VLD,
    input  Frame_Count,
    input  Retry_Err
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Pops words from a FWFT async FIFO and hands them one at a time to a UART TX, re-strobing when Busy never rises.
// Optional inter-frame gap (GAP state and counter) is compiled in when UART_TX_GAP_EN is defined.
module uart_tx_sched #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic            CLK,
  input  logic            RST,
  uart_tx_sched_if.master bus
);

  if (BUSY_TIMEOUT < 1 || BUSY_TIMEOUT > 15) begin : g_bad_timeout
    $error("uart_tx_sched: BUSY_TIMEOUT must be within 1..15");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("uart_tx_sched: GAP_CYCLES must be within 1..15");
  end

  // Counter value of the last WAIT_START cycle before a retry: BUSY_TIMEOUT cycles total.
  localparam logic [3:0] TMO_LAST = 4'(BUSY_TIMEOUT - 1);

`ifdef UART_TX_GAP_EN
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND       = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    GAP        = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND       = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3
  } state_t;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_tmo_cnt;
  logic [3:0]            w_tmo_cnt_nxt;
  logic                  r_rd_inc;
  logic                  w_rd_inc_nxt;
  logic                  r_tx_vld;
  logic                  w_tx_vld_nxt;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [DATA_WIDTH-1:0] w_tx_data_nxt;
  logic [7:0]            r_frame_cnt;
  logic [7:0]            w_frame_cnt_nxt;
  logic                  r_retry_err;
  logic                  w_retry_err_nxt;
  logic                  w_start;
`ifdef UART_TX_GAP_EN
  logic [3:0]            r_gap_cnt;
  logic [3:0]            w_gap_cnt_nxt;
`endif

  assign w_start = bus.Sched_EN & ~bus.FIFO_EMPTY & ~bus.TX_Busy;

  // Next-state and next-output decode; strobes are computed here and registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_rd_inc_nxt    = 1'b0;
    w_tx_vld_nxt    = 1'b0;
    w_tx_data_nxt   = r_tx_data;
    w_frame_cnt_nxt = r_frame_cnt;
    w_retry_err_nxt = r_retry_err;
`ifdef UART_TX_GAP_EN
    w_gap_cnt_nxt   = r_gap_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt   = SEND;
          w_rd_inc_nxt  = 1'b1;
          w_tx_data_nxt = bus.FIFO_RdData;
        end else begin
          w_state_nxt   = IDLE;
        end
      end
      SEND: begin
        w_state_nxt   = WAIT_START;
        w_tx_vld_nxt  = 1'b1;
        w_tmo_cnt_nxt = 4'd0;
      end
      WAIT_START: begin
        if (bus.TX_Busy) begin
          w_state_nxt     = WAIT_DONE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          // Lost strobe: re-send the held byte without touching the FIFO.
          w_state_nxt     = SEND;
          w_retry_err_nxt = 1'b1;
        end else begin
          w_tmo_cnt_nxt   = r_tmo_cnt + 4'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.TX_Busy) begin
          w_frame_cnt_nxt = r_frame_cnt + 8'd1;
`ifdef UART_TX_GAP_EN
          w_state_nxt     = GAP;
          w_gap_cnt_nxt   = 4'd0;
`else
          w_state_nxt     = IDLE;
`endif
        end else begin
          w_state_nxt     = WAIT_DONE;
        end
      end
`ifdef UART_TX_GAP_EN
      GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt   = IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 4'd1;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_tmo_cnt   <= 4'd0;
      r_rd_inc    <= 1'b0;
      r_tx_vld    <= 1'b0;
      r_tx_data   <= '0;
      r_frame_cnt <= 8'd0;
      r_retry_err <= 1'b0;
`ifdef UART_TX_GAP_EN
      r_gap_cnt   <= 4'd0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_rd_inc    <= w_rd_inc_nxt;
      r_tx_vld    <= w_tx_vld_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_retry_err <= w_retry_err_nxt;
`ifdef UART_TX_GAP_EN
      r_gap_cnt   <= w_gap_cnt_nxt;
`endif
    end
  end

  assign bus.FIFO_RdInc  = r_rd_inc;
  assign bus.TX_D_VLD    = r_tx_vld;
  assign bus.TX_P_Data   = r_tx_data;
  assign bus.Frame_Count = r_frame_cnt;
  assign bus.Retry_Err   = r_retry_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: FIFO and UART behavioural models, directed scenarios and a random phase.
module tb_uart_tx_sched;

`ifdef UART_TX_GAP_EN
  localparam int GAP_EXP = 3;
`else
  localparam int GAP_EXP = 0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;

  uart_tx_sched_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_sched #(
    .DATA_WIDTH  (8),
    .BUSY_TIMEOUT(4),
    .GAP_CYCLES  (3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  logic [7:0] fifo_q[$];
  logic [7:0] pushed_q[$];
  logic [7:0] sent_q[$];
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_pop = 0;
  int n_vld = 0;
  int busy_left = 0;
  int ext_busy = 0;
  int busy_len = 10;
  int ignore_cnt = 0;
  int ignored_total = 0;
  int frames_model = 0;
  int last_pop_cyc = -1;
  int last_vld_cyc = -1;
  int prev_vld_cyc = -1;
  int busy_fall_cyc = -1;
  int push_cyc = 0;
  bit track_gap = 1'b0;
  bit obs_event = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    bus.FIFO_EMPTY  = (fifo_q.size() == 0);
    bus.FIFO_RdData = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    bus.TX_Busy     = (busy_left > 0) || (ext_busy > 0);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    pushed_q.push_back(b);
    drive_inputs();
  endtask

  // One clock: observe DUT at the falling edge, then let FIFO/UART models react to the rising edge.
  task automatic step();
    logic       s_rdinc, s_vld, s_empty, s_busy;
    logic [7:0] s_data;
    @(negedge CLK);
    s_rdinc = bus.FIFO_RdInc;
    s_vld   = bus.TX_D_VLD;
    s_empty = bus.FIFO_EMPTY;
    s_busy  = bus.TX_Busy;
    s_data  = bus.TX_P_Data;
    obs_event = s_rdinc | s_vld;
    check("pop_while_empty", {31'd0, s_rdinc & s_empty}, 32'd0);
    if (s_busy && sent_q.size() > 0) check("data_stable_busy", {24'd0, s_data}, {24'd0, sent_q[$]});
    if (track_gap && s_rdinc && busy_fall_cyc >= 0)
      check("gap_spacing", 32'(cyc - busy_fall_cyc), 32'(2 + GAP_EXP));
    if (s_rdinc) begin
      n_pop++;
      last_pop_cyc = cyc;
    end
    if (s_vld) begin
      n_vld++;
      prev_vld_cyc = last_vld_cyc;
      last_vld_cyc = cyc;
    end
    @(posedge CLK);
    cyc++;
    #1;
    if (s_rdinc && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (ext_busy > 0) ext_busy--;
    if (s_vld) begin
      if (ignore_cnt > 0) begin
        ignore_cnt--;
        ignored_total++;
      end else begin
        busy_left = busy_len;
        sent_q.push_back(s_data);
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        frames_model++;
        busy_fall_cyc = cyc;
      end
    end
    drive_inputs();
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    int quiet = 0;
    while (quiet < 8 && k < budget) begin
      step();
      k++;
      if (fifo_q.size() == 0 && busy_left == 0 && !obs_event) quiet++;
      else quiet = 0;
    end
    check(tag, 32'(quiet >= 8), 32'd1);
  endtask

  task automatic wait_vld(input string tag, input int target, input int budget);
    int k = 0;
    while (n_vld < target && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(n_vld >= target), 32'd1);
  endtask

  initial begin
    int p0, v0, f0;
    bus.Sched_EN = 1'b1;
    drive_inputs();

    // Reset state
    repeat (3) step();
    check("rst_rdinc", {31'd0, bus.FIFO_RdInc}, 32'd0);
    check("rst_vld", {31'd0, bus.TX_D_VLD}, 32'd0);
    check("rst_data", {24'd0, bus.TX_P_Data}, 32'd0);
    check("rst_frames", {24'd0, bus.Frame_Count}, 32'd0);
    check("rst_retry", {31'd0, bus.Retry_Err}, 32'd0);
    RST = 1'b1;
    repeat (2) step();

    // Scenario 1: single word, latency from FIFO_EMPTY falling
    p0 = n_pop; v0 = n_vld;
    push_cyc = cyc;
    push(8'h5A);
    wait_vld("s1_vld_seen", v0 + 1, 10);
    check("s1_pop_latency", 32'(last_pop_cyc - push_cyc), 32'd1);
    check("s1_vld_latency", 32'(last_vld_cyc - push_cyc), 32'd2);
    check("s1_data", {24'd0, bus.TX_P_Data}, 32'h5A);
    drain("s1_drain", 100);
    check("s1_pops", 32'(n_pop - p0), 32'd1);
    check("s1_vlds", 32'(n_vld - v0), 32'd1);
    check("s1_frames", {24'd0, bus.Frame_Count}, 32'd1);
    check("s1_retry", {31'd0, bus.Retry_Err}, 32'd0);

    // Scenario 2: three back-to-back words, gap between Busy falling and the next pop
    p0 = n_pop;
    busy_fall_cyc = -1;
    track_gap = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    drain("s2_drain", 200);
    track_gap = 1'b0;
    check("s2_pops", 32'(n_pop - p0), 32'd3);
    check("s2_frames", {24'd0, bus.Frame_Count}, 32'(frames_model % 256));
    check("s2_last_byte", {24'd0, sent_q[$]}, 32'h33);

    // TX_Busy high while idle blocks a start until it falls
    p0 = n_pop;
    ext_busy = 6;
    push(8'hC7);
    repeat (7) step();
    check("busy_blocks_start", 32'(n_pop - p0), 32'd0);
    step();
    check("start_after_busy", 32'(n_pop - p0), 32'd1);
    drain("busy_blk_drain", 100);

    // Scenario 4: Sched_EN low holds queued words; high releases them
    p0 = n_pop; v0 = n_vld;
    bus.Sched_EN = 1'b0;
    push(8'h4D); push(8'hE2);
    repeat (50) step();
    check("s4_no_pop", 32'(n_pop - p0), 32'd0);
    check("s4_no_vld", 32'(n_vld - v0), 32'd0);
    bus.Sched_EN = 1'b1;
    drain("s4_drain", 200);
    check("s4_pops", 32'(n_pop - p0), 32'd2);

    // Sched_EN falling mid-frame does not abort the frame
    f0 = frames_model; v0 = n_vld;
    push(8'h96);
    wait_vld("en_mid_vld", v0 + 1, 10);
    bus.Sched_EN = 1'b0;
    drain("en_mid_drain", 100);
    check("en_mid_done", 32'(frames_model - f0), 32'd1);
    check("en_mid_frames", {24'd0, bus.Frame_Count}, 32'(frames_model % 256));
    bus.Sched_EN = 1'b1;

    // Randomized phase: random bytes, arrivals, Sched_EN and Busy lengths
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) push(8'($urandom));
      bus.Sched_EN = ($urandom_range(0, 3) != 0);
      busy_len = $urandom_range(1, 12);
      step();
    end
    bus.Sched_EN = 1'b1;
    drain("rand_drain", 3000);
    check("rand_frames", {24'd0, bus.Frame_Count}, 32'(frames_model % 256));
    check("rand_pops", 32'(n_pop), 32'(pushed_q.size()));

    // Scenario 3: first strobe ignored, retry after BUSY_TIMEOUT
    busy_len = 10;
    p0 = n_pop; v0 = n_vld;
    ignore_cnt = 1;
    push(8'h3C);
    wait_vld("s3_two_vld", v0 + 2, 30);
    check("s3_retry_spacing", 32'(last_vld_cyc - prev_vld_cyc), 32'd5);
    check("s3_retry_data", {24'd0, bus.TX_P_Data}, 32'h3C);
    drain("s3_drain", 100);
    check("s3_one_pop", 32'(n_pop - p0), 32'd1);
    check("s3_retry_err", {31'd0, bus.Retry_Err}, 32'd1);
    check("s3_sent", {24'd0, sent_q[$]}, 32'h3C);

    // Scenario 5: reset during WAIT_DONE
    p0 = n_pop;
    push(8'hA1); push(8'hA2);
    begin
      int k = 0;
      while (busy_left == 0 && k < 20) begin step(); k++; end
      check("s5_busy_seen", 32'(busy_left > 0), 32'd1);
    end
    repeat (2) step();
    RST = 1'b0;
    busy_left = 0;
    frames_model = 0;
    drive_inputs();
    #1;
    check("s5_rdinc", {31'd0, bus.FIFO_RdInc}, 32'd0);
    check("s5_vld", {31'd0, bus.TX_D_VLD}, 32'd0);
    check("s5_data", {24'd0, bus.TX_P_Data}, 32'd0);
    check("s5_frames", {24'd0, bus.Frame_Count}, 32'd0);
    check("s5_retry", {31'd0, bus.Retry_Err}, 32'd0);
    repeat (2) step();
    RST = 1'b1;
    drain("s5_drain", 100);
    check("s5_pops", 32'(n_pop - p0), 32'd2);
    check("s5_after_frames", {24'd0, bus.Frame_Count}, 32'd1);
    check("s5_after_byte", {24'd0, sent_q[$]}, 32'hA2);

    // Frame_Count wrap: 255 more frames takes the count from 1 through 255 to 0
    busy_len = 2;
    for (int i = 0; i < 255; i++) push(8'($urandom));
    drain("wrap_drain", 255 * 20);
    check("wrap_model", {24'd0, bus.Frame_Count}, 32'(frames_model % 256));
    check("wrap_zero", {24'd0, bus.Frame_Count}, 32'd0);

    // End-to-end: every pushed word popped once and transmitted once, in order
    check("total_pops", 32'(n_pop), 32'(pushed_q.size()));
    check("total_sent", 32'(sent_q.size()), 32'(pushed_q.size()));
    check("total_vld", 32'(n_vld), 32'(sent_q.size() + ignored_total));
    for (int i = 0; i < pushed_q.size() && i < sent_q.size(); i++)
      check("order", {24'd0, sent_q[i]}, {24'd0, pushed_q[i]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
